mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
Moore-style FSM that sequences the multicycle MIPS datapath: PC, instruction/data memory, register file and ALU.
- Decodes opcode/funct and drives per-state control strobes, including RegisterWrite, MemoryToRegister, MemoryWrite, Branch and ALUSrc-class selects.
- Stalls on a memory ready handshake.
- Counts retired instructions.
- Traps on illegal opcodes and memory timeouts.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- STALL_LIMIT, 16, max consecutive cycles a memory state waits for mem_ready before trapping (range 1..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- opcode  input  6  instruction[31:26], valid from DECODE onward.
- funct  input  6  instruction[5:0]; used only for illegal R-type detection.
- mem_ready  input  1  memory completion for the current access.
- PCWrite  output  1  unconditional PC load.
- Branch  output  1  conditional PC load; datapath gates it with ALU zero.
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- MemoryRead  output  1  memory read strobe.
- MemoryWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- MemoryToRegister  output  1  writeback source: 1 = MDR, 0 = ALUOut.
- RegDst  output  1  destination register: 1 = rd, 0 = rt.
- RegisterWrite  output  1  register file write enable.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- ALUOp  output  2  00 = add, 01 = sub, 10 = use funct.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  output  1  one-cycle pulse on the final state of each instruction.
- retired  output  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.
- illegal  output  1  sticky; illegal opcode/funct seen.
- mem_timeout  output  1  sticky; STALL_LIMIT reached.
- state  output  4  current state encoding, for debug.

Behaviour:
- Reset (rst = 0), asynchronous:
  - State goes to IDLE; retired = 0; illegal = 0; mem_timeout = 0; wait counter = 0.
  - IDLE drives every strobe/select to 0.
  - On the first clock after release, state goes to FETCH.
- All control outputs are decoded from state only (Moore). Strobes not listed for a state are 0.
- States and transitions:
  - IDLE(0) -> FETCH.
  - FETCH(1): MemoryRead, IRWrite, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
    - PCWrite and IRWrite are asserted only in the cycle mem_ready = 1.
    - Holds while mem_ready = 0; goes to DECODE on mem_ready.
  - DECODE(2): ALUSrcB = 11, ALUOp = 00. Next state by opcode:
    - 000000 -> EXEC. If funct is not one of add 100000, sub 100010, and 100100, or 100101, slt 101010, go to TRAP instead.
    - 100011 / 101011 -> MEMADR.
    - 001000 -> ADDI_EX.
    - 000100 -> BRANCH.
    - 000010 -> JUMP.
    - Any other opcode -> TRAP.
  - MEMADR(3): ALUSrcA = 1, ALUSrcB = 10. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD(4): MemoryRead, IorD. Waits for mem_ready, then MEMWB.
  - MEMWB(5): RegisterWrite, MemoryToRegister, RegDst = 0; instr_done -> FETCH.
  - MEMWR(6): MemoryWrite, IorD. Waits for mem_ready; instr_done on the completing cycle -> FETCH.
  - EXEC(7): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> RWB.
  - RWB(8): RegisterWrite, RegDst = 1, MemoryToRegister = 0; instr_done -> FETCH.
  - ADDI_EX(9): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00 -> ADDI_WB.
  - ADDI_WB(10): RegisterWrite, RegDst = 0; instr_done -> FETCH.
  - BRANCH(11): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, Branch, PCSource = 01; instr_done -> FETCH.
  - JUMP(12): PCWrite, PCSource = 10; instr_done -> FETCH.
  - TRAP(13): all strobes 0. Absorbing; left only by reset.
- Memory wait states (FETCH, MEMRD, MEMWR):
  - Wait counter clears on entry and increments each cycle mem_ready = 0.
  - When the counter reaches STALL_LIMIT with mem_ready still 0: next state = TRAP and mem_timeout is set.
  - mem_ready = 1 in the same cycle the limit is reached takes priority (normal completion).
- Illegal opcode/funct sets illegal on the DECODE -> TRAP edge.
- retired increments by 1 on every instr_done cycle; all-ones wraps to 0.
- Cycle counts with mem_ready held 1: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3.
- Reset asserted mid-instruction aborts immediately. No strobe survives the reset edge.

Test Plan:
- Reset release, mem_ready = 1, R-type add (opcode 0, funct 0x20) -> states 1, 2, 7, 8; RegisterWrite = 1 and RegDst = 1 only in state 8; instr_done pulses once; retired = 1.
- lw (0x23), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles; MemoryToRegister = 1 with RegisterWrite in MEMWB; 8 cycles total.
- sw (0x2B) then beq (0x04) then j (0x02) -> MemoryWrite only in MEMWR; Branch only in BRANCH; PCWrite with PCSource = 10 in JUMP; retired = 3 after 10 cycles.
- Opcode 0x3F, and separately R-type funct 0x01 -> TRAP at cycle 3, illegal = 1, all strobes 0 for 20 further cycles.
- STALL_LIMIT = 4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, mem_timeout = 1; mem_ready rising exactly at cycle 4 -> DECODE instead, no flag.
- CNT_W = 3, 9 addi instructions -> retired wraps 7 -> 0 -> 1. rst pulsed low while in MEMWR -> outputs 0 asynchronously, retired = 0, then IDLE -> FETCH.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore sequencer for the shared-memory datapath,
// with memory-ready stalls, a retired-instruction counter and sticky trap flags.
module mips_multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             Branch,
  output logic             IorD,
  output logic             MemoryRead,
  output logic             MemoryWrite,
  output logic             IRWrite,
  output logic             MemoryToRegister,
  output logic             RegDst,
  output logic             RegisterWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             mem_timeout,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXEC    = 4'd7,
    RWB     = 4'd8,
    ADDI_EX = 4'd9,
    ADDI_WB = 4'd10,
    BRANCH  = 4'd11,
    JUMP    = 4'd12,
    TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Value of the wait counter on the last stalled cycle a memory state may absorb.
  localparam logic [7:0] LAST_WAIT = 8'(STALL_LIMIT - 1);

  state_t     curState;
  state_t     nextState;
  logic [7:0] waitCnt;
  logic       isLoad;
  logic       memState;
  logic       stallExpired;
  logic       legalFunct;
  logic       trapIllegal;
  logic       trapTimeout;

  assign state    = curState;
  assign memState = (curState == FETCH) || (curState == MEMRD) || (curState == MEMWR);
  // A completing access in the limit cycle wins, so the expiry needs mem_ready low.
  assign stallExpired = memState && !mem_ready && (waitCnt == LAST_WAIT);

  always_comb begin
    legalFunct = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legalFunct = 1'b1;
      default:                               legalFunct = 1'b0;
    endcase
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    nextState        = curState;
    trapIllegal      = 1'b0;
    trapTimeout      = 1'b0;
    PCWrite          = 1'b0;
    Branch           = 1'b0;
    IorD             = 1'b0;
    MemoryRead       = 1'b0;
    MemoryWrite      = 1'b0;
    IRWrite          = 1'b0;
    MemoryToRegister = 1'b0;
    RegDst           = 1'b0;
    RegisterWrite    = 1'b0;
    ALUSrcA          = 1'b0;
    ALUSrcB          = 2'b00;
    ALUOp            = 2'b00;
    PCSource         = 2'b00;
    instr_done       = 1'b0;

    case (curState)
      IDLE: nextState = FETCH;

      FETCH: begin
        MemoryRead = 1'b1;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        ALUSrcB    = 2'b01;
        if (mem_ready) begin
          nextState = DECODE;
        end else if (stallExpired) begin
          nextState   = TRAP;
          trapTimeout = 1'b1;
        end
      end

      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE: begin
            if (legalFunct) begin
              nextState = EXEC;
            end else begin
              nextState   = TRAP;
              trapIllegal = 1'b1;
            end
          end
          OP_LW, OP_SW: nextState = MEMADR;
          OP_ADDI:      nextState = ADDI_EX;
          OP_BEQ:       nextState = BRANCH;
          OP_J:         nextState = JUMP;
          default: begin
            nextState   = TRAP;
            trapIllegal = 1'b1;
          end
        endcase
      end

      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nextState = isLoad ? MEMRD : MEMWR;
      end

      MEMRD: begin
        MemoryRead = 1'b1;
        IorD       = 1'b1;
        if (mem_ready) begin
          nextState = MEMWB;
        end else if (stallExpired) begin
          nextState   = TRAP;
          trapTimeout = 1'b1;
        end
      end

      MEMWB: begin
        RegisterWrite    = 1'b1;
        MemoryToRegister = 1'b1;
        instr_done       = 1'b1;
        nextState        = FETCH;
      end

      MEMWR: begin
        MemoryWrite = 1'b1;
        IorD        = 1'b1;
        instr_done  = mem_ready;
        if (mem_ready) begin
          nextState = FETCH;
        end else if (stallExpired) begin
          nextState   = TRAP;
          trapTimeout = 1'b1;
        end
      end

      EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        nextState = RWB;
      end

      RWB: begin
        RegisterWrite = 1'b1;
        RegDst        = 1'b1;
        instr_done    = 1'b1;
        nextState     = FETCH;
      end

      ADDI_EX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nextState = ADDI_WB;
      end

      ADDI_WB: begin
        RegisterWrite = 1'b1;
        instr_done    = 1'b1;
        nextState     = FETCH;
      end

      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        PCSource   = 2'b01;
        instr_done = 1'b1;
        nextState  = FETCH;
      end

      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
        nextState  = FETCH;
      end

      TRAP: nextState = TRAP;

      // Unused encodings park in TRAP so no strobe can fire from a corrupted state.
      default: nextState = TRAP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curState    <= IDLE;
      waitCnt     <= 8'd0;
      isLoad      <= 1'b0;
      retired     <= '0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      curState <= nextState;

      if (nextState != curState) begin
        waitCnt <= 8'd0;
      end else if (memState && !mem_ready) begin
        waitCnt <= waitCnt + 8'd1;
      end

      if (curState == DECODE) begin
        isLoad <= (opcode == OP_LW);
      end

      if (instr_done) begin
        retired <= retired + CNT_W'(1);
      end

      if (trapIllegal) begin
        illegal <= 1'b1;
      end
      if (trapTimeout) begin
        mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed instruction table, trap/timeout/reset
// sequences, and random instruction streams checked against a per-instruction path model.
module tb_mips_multicycle_control;

  localparam int CNT_W       = 3;
  localparam int STALL_LIMIT = 4;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5,  S_MEMWR = 4'd6,   S_EXEC = 4'd7;
  localparam logic [3:0] S_RWB = 4'd8,   S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP = 4'd12, S_TRAP = 4'd13;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       opcode = 6'd0;
  logic [5:0]       funct = 6'd0;
  logic             mem_ready = 1'b0;
  logic             PCWrite, Branch, IorD, MemoryRead, MemoryWrite, IRWrite;
  logic             MemoryToRegister, RegDst, RegisterWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic             instr_done;
  logic [CNT_W-1:0] retired;
  logic             illegal, mem_timeout;
  logic [3:0]       state;

  typedef struct packed {
    logic       pcWrite, branch, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic       done;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    int         fStall;
    int         mStall;
    int         cycles;
  } vec_t;

  ctl_t             ctl;
  step_t            plan[$];
  vec_t             vecs[12];
  logic [CNT_W-1:0] expRetired = '0;
  int               total = 0;
  int               bad = 0;

  always #5 clk = ~clk;

  assign ctl = {PCWrite, Branch, IorD, MemoryRead, MemoryWrite, IRWrite, MemoryToRegister,
                RegDst, RegisterWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};

  mips_multicycle_control #(.CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemoryRead(MemoryRead),
    .MemoryWrite(MemoryWrite), .IRWrite(IRWrite), .MemoryToRegister(MemoryToRegister),
    .RegDst(RegDst), .RegisterWrite(RegisterWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .instr_done(instr_done), .retired(retired),
    .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
  );

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // Control word each state must present, written straight from the state descriptions.
  function automatic ctl_t ctlFor(input logic [3:0] st, input logic rdy);
    ctl_t c = '0;
    case (st)
      S_FETCH:  begin c.memRead = 1'b1; c.irWrite = rdy; c.pcWrite = rdy; c.aluSrcB = 2'b01; end
      S_DECODE: c.aluSrcB = 2'b11;
      S_MEMADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      S_MEMRD:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
      S_MEMWB:  begin c.regWrite = 1'b1; c.memToReg = 1'b1; c.done = 1'b1; end
      S_MEMWR:  begin c.memWrite = 1'b1; c.iorD = 1'b1; c.done = rdy; end
      S_EXEC:   begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
      S_RWB:    begin c.regWrite = 1'b1; c.regDst = 1'b1; c.done = 1'b1; end
      S_ADDIEX: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      S_ADDIWB: begin c.regWrite = 1'b1; c.done = 1'b1; end
      S_BRANCH: begin c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.branch = 1'b1; c.pcSource = 2'b01; c.done = 1'b1; end
      S_JUMP:   begin c.pcWrite = 1'b1; c.pcSource = 2'b10; c.done = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushStep(input logic [3:0] st, input logic rdy);
    step_t s;
    s.st  = st;
    s.rdy = rdy;
    plan.push_back(s);
  endtask

  // Memory states: n stalled cycles, then the completing one.
  task automatic pushWait(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) pushStep(st, 1'b0);
    pushStep(st, 1'b1);
  endtask

  // Path of one legal instruction through the machine, as a list of states.
  task automatic buildPlan(input logic [5:0] op, input int fStall, input int mStall);
    plan.delete();
    pushWait(S_FETCH, fStall);
    pushStep(S_DECODE, rnd());
    case (op)
      6'h00: begin pushStep(S_EXEC, rnd()); pushStep(S_RWB, rnd()); end
      6'h23: begin pushStep(S_MEMADR, rnd()); pushWait(S_MEMRD, mStall); pushStep(S_MEMWB, rnd()); end
      6'h2B: begin pushStep(S_MEMADR, rnd()); pushWait(S_MEMWR, mStall); end
      6'h08: begin pushStep(S_ADDIEX, rnd()); pushStep(S_ADDIWB, rnd()); end
      6'h04: pushStep(S_BRANCH, rnd());
      default: pushStep(S_JUMP, rnd());
    endcase
  endtask

  // Opcode/funct are junk during FETCH and valid from DECODE onward.
  task automatic stepChk(input logic [3:0] expSt, input logic [5:0] op, input logic [5:0] fn,
                         input logic rdy, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    if (expSt == S_FETCH) begin
      opcode = 6'($urandom);
      funct  = 6'($urandom);
    end else begin
      opcode = op;
      funct  = fn;
    end
    #1;
    check({tag, " state"}, 32'(state), 32'(expSt));
    check({tag, " ctl"}, 32'(ctl), 32'(ctlFor(expSt, rdy)));
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int fStall,
                          input int mStall, output int doneAt, output int planLen);
    logic [5:0] useFn;
    useFn = (op == 6'h00) ? fn : 6'($urandom);
    buildPlan(op, fStall, mStall);
    planLen = plan.size();
    doneAt  = 0;
    for (int i = 0; i < plan.size(); i++) begin
      stepChk(plan[i].st, op, useFn, plan[i].rdy, "instr");
      check("retired", 32'(retired), 32'(expRetired));
      check("flags", 32'({illegal, mem_timeout}), 32'd0);
      if (instr_done && doneAt == 0) doneAt = i + 1;
    end
    expRetired = expRetired + 1'b1;
  endtask

  task automatic doReset();
    rst       = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'd0;
    funct     = 6'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset state", 32'(state), 32'(S_IDLE));
    check("reset ctl", 32'(ctl), 32'd0);
    check("reset retired", 32'(retired), 32'd0);
    check("reset flags", 32'({illegal, mem_timeout}), 32'd0);
    rst        = 1'b1;
    expRetired = '0;
  endtask

  task automatic trapTest(input logic [5:0] op, input logic [5:0] fn, input string tag);
    doReset();
    stepChk(S_FETCH, op, fn, 1'b1, tag);
    stepChk(S_DECODE, op, fn, rnd(), tag);
    check({tag, " illegal before trap"}, 32'(illegal), 32'd0);
    for (int i = 0; i < 21; i++) begin
      stepChk(S_TRAP, 6'($urandom), 6'($urandom), rnd(), tag);
      check({tag, " illegal"}, 32'(illegal), 32'd1);
      check({tag, " timeout flag"}, 32'(mem_timeout), 32'd0);
    end
  endtask

  initial begin
    int doneAt;
    int planLen;
    logic [5:0] fnList[5];

    vecs[0]  = '{"add",        6'h00, 6'h20, 0, 0, 4};
    vecs[1]  = '{"lw stall3",  6'h23, 6'h00, 0, 3, 8};
    vecs[2]  = '{"sw",         6'h2B, 6'h00, 0, 0, 4};
    vecs[3]  = '{"beq",        6'h04, 6'h00, 0, 0, 3};
    vecs[4]  = '{"j",          6'h02, 6'h00, 0, 0, 3};
    vecs[5]  = '{"sub fstall", 6'h00, 6'h22, 3, 0, 7};
    vecs[6]  = '{"and",        6'h00, 6'h24, 0, 0, 4};
    vecs[7]  = '{"or",         6'h00, 6'h25, 1, 0, 5};
    vecs[8]  = '{"slt",        6'h00, 6'h2A, 0, 0, 4};
    vecs[9]  = '{"addi",       6'h08, 6'h00, 2, 0, 6};
    vecs[10] = '{"sw stalls",  6'h2B, 6'h00, 2, 3, 9};
    vecs[11] = '{"lw stalls",  6'h23, 6'h00, 3, 3, 11};
    fnList   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    #1;
    doReset();
    for (int i = 0; i < 12; i++) begin
      runInstr(vecs[i].op, vecs[i].fn, vecs[i].fStall, vecs[i].mStall, doneAt, planLen);
      check({"cycles ", vecs[i].name}, 32'(doneAt), 32'(vecs[i].cycles));
    end

    // Nine addi from reset: the 3-bit counter wraps 7 -> 0 -> 1.
    doReset();
    for (int i = 0; i < 9; i++) runInstr(6'h08, 6'h00, 0, 0, doneAt, planLen);
    @(posedge clk);
    #1;
    check("retired wrap", 32'(retired), 32'd1);

    trapTest(6'h3F, 6'h20, "bad opcode");
    trapTest(6'h00, 6'h01, "bad funct");

    // FETCH starved: four stalled cycles, then TRAP with mem_timeout.
    doReset();
    for (int i = 0; i < STALL_LIMIT; i++) begin
      stepChk(S_FETCH, 6'h08, 6'h00, 1'b0, "fetch starve");
      check("starve timeout early", 32'(mem_timeout), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      stepChk(S_TRAP, 6'h08, 6'h00, 1'b1, "fetch starve");
      check("starve timeout", 32'(mem_timeout), 32'd1);
      check("starve illegal", 32'(illegal), 32'd0);
    end

    // Ready arriving in the limit cycle completes normally.
    doReset();
    for (int i = 0; i < STALL_LIMIT - 1; i++) stepChk(S_FETCH, 6'h08, 6'h00, 1'b0, "edge ready");
    stepChk(S_FETCH, 6'h08, 6'h00, 1'b1, "edge ready");
    stepChk(S_DECODE, 6'h08, 6'h00, 1'b0, "edge ready");
    stepChk(S_ADDIEX, 6'h08, 6'h00, 1'b0, "edge ready");
    check("edge ready no timeout", 32'(mem_timeout), 32'd0);

    // MEMRD starved.
    doReset();
    stepChk(S_FETCH, 6'h23, 6'h00, 1'b1, "memrd starve");
    stepChk(S_DECODE, 6'h23, 6'h00, 1'b1, "memrd starve");
    stepChk(S_MEMADR, 6'h23, 6'h00, 1'b1, "memrd starve");
    for (int i = 0; i < STALL_LIMIT; i++) stepChk(S_MEMRD, 6'h23, 6'h00, 1'b0, "memrd starve");
    stepChk(S_TRAP, 6'h23, 6'h00, 1'b1, "memrd starve");
    check("memrd timeout", 32'(mem_timeout), 32'd1);

    // Reset asserted mid-MEMWR drops every strobe without a clock edge.
    doReset();
    runInstr(6'h08, 6'h00, 0, 0, doneAt, planLen);
    stepChk(S_FETCH, 6'h2B, 6'h00, 1'b1, "abort");
    stepChk(S_DECODE, 6'h2B, 6'h00, 1'b1, "abort");
    stepChk(S_MEMADR, 6'h2B, 6'h00, 1'b1, "abort");
    stepChk(S_MEMWR, 6'h2B, 6'h00, 1'b0, "abort");
    check("abort retired before", 32'(retired), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort state", 32'(state), 32'(S_IDLE));
    check("abort ctl", 32'(ctl), 32'd0);
    check("abort retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst        = 1'b1;
    expRetired = '0;
    #1;
    check("abort idle", 32'(state), 32'(S_IDLE));
    stepChk(S_FETCH, 6'h08, 6'h00, 1'b1, "abort restart");

    // Random legal instruction stream with random stalls below the limit.
    doReset();
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h08;
        4: op = 6'h04;
        default: op = 6'h02;
      endcase
      runInstr(op, fnList[$urandom_range(0, 4)], $urandom_range(0, STALL_LIMIT - 1),
               $urandom_range(0, STALL_LIMIT - 1), doneAt, planLen);
      check("random done cycle", 32'(doneAt), 32'(planLen));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
